// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock set/alarm controller: state encoding,
// field widths, default wrap limits and alarm duration.
// No ports; imported by clock_set_ctrl and clock_alarm_match.
package clock_set_ctrl_pkg;

    localparam int HR_W            = 5;
    localparam int MIN_W           = 6;
    localparam int SEC_W           = 6;
    localparam int HR_MAX_DEF      = 23;
    localparam int MIN_MAX_DEF     = 59;
    localparam int ALARM_TICKS_DEF = 60;

    // The encoding doubles as the 'mode' display output, so it is fixed.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_ALM_HR  = 3'd4,
        ST_ALM_MIN = 3'd5
    } state_e;

    // Increment with wrap by compare against the last legal value. Anything
    // at or above the limit snaps back to zero, so a field can never walk
    // out of range even if it was captured from a bad input.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val,
                                            input logic [5:0] last_val);
        return (val >= last_val) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/clock_alarm_match.sv
// Alarm match, duration counter and re-trigger guard.
// Latency: alarm_fire rises the cycle after the matching tick; clears on the
// cycle after the ALARM_TICKS-th following tick or a dismiss press.
// Ports: clk, rst (async active-low), tick_1hz, check_en (RUN/ALM_* states),
// alarm_on, cur_* live time, alarm_hr/min, dismiss -> alarm_fire.
module clock_alarm_match
    import clock_set_ctrl_pkg::*;
#(
    parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             check_en,
    input  logic             alarm_on,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             dismiss,
    output logic             alarm_fire
);

    localparam int                CNT_W    = $clog2(ALARM_TICKS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ALARM_TICKS - 1);

    logic             fire_q, fire_d;
    logic             guard_q, guard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hm_match;
    logic             trigger;

    assign hm_match = (cur_hr == alarm_hr) && (cur_min == alarm_min);
    assign trigger  = tick_1hz && check_en && alarm_on && hm_match &&
                      (cur_sec == '0) && !guard_q && !fire_q;

    always_comb begin
        fire_d  = fire_q;
        cnt_d   = cnt_q;
        // The guard holds for as long as the live time stays in the alarm
        // minute, so one matching minute can fire at most once.
        guard_d = hm_match ? guard_q : 1'b0;
        if (fire_q) begin
            if (dismiss) begin
                fire_d = 1'b0;
                cnt_d  = '0;
            end else if (tick_1hz) begin
                if (cnt_q == LAST_CNT) begin
                    fire_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (trigger) begin
            fire_d  = 1'b1;
            cnt_d   = '0;
            guard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q  <= 1'b0;
            guard_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fire_q  <= fire_d;
            guard_q <= guard_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm_fire = fire_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock time-set and alarm controller: button-driven edit FSM, load strobe
// to the time counter, alarm storage and alarm sounding.
// Ports: clk, rst (async active-low), tick_1hz, btn_mode/btn_inc pulses,
// cur_* live time in; cnt_en, ld/ld_*, edit_*, mode, blink, alarm_* out.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int HR_MAX      = HR_MAX_DEF,
    parameter int MIN_MAX     = MIN_MAX_DEF,
    parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       cnt_en,
    output logic       ld,
    output logic [4:0] ld_hr,
    output logic [5:0] ld_min,
    output logic [5:0] ld_sec,
    output logic [4:0] edit_hr,
    output logic [5:0] edit_min,
    output logic [2:0] mode,
    output logic       blink,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       alarm_on,
    output logic       alarm_fire
);

    localparam logic [5:0] HR_LAST  = 6'(HR_MAX);
    localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);

    state_e     state_q, state_d;
    logic [4:0] edit_hr_q, edit_hr_d;
    logic [5:0] edit_min_q, edit_min_d;
    logic [4:0] alarm_hr_q, alarm_hr_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic       alarm_on_q, alarm_on_d;
    logic       blink_q, blink_d;

    logic       live;
    logic       mode_act;
    logic       inc_act;
    logic       dismiss;

    // Time runs in RUN and while editing the alarm; frozen while setting.
    assign live = (state_q == ST_RUN) || (state_q == ST_ALM_HR) ||
                  (state_q == ST_ALM_MIN);

    // A press while the alarm sounds only silences it. Mode beats inc.
    assign dismiss  = alarm_fire && (btn_mode || btn_inc);
    assign mode_act = btn_mode && !alarm_fire;
    assign inc_act  = btn_inc && !btn_mode && !alarm_fire;

    always_comb begin
        state_d     = state_q;
        edit_hr_d   = edit_hr_q;
        edit_min_d  = edit_min_q;
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        alarm_on_d  = alarm_on_q;
        blink_d     = blink_q;

        unique case (state_q)
            ST_RUN: begin
                if (mode_act) begin
                    state_d    = ST_SET_HR;
                    edit_hr_d  = cur_hr;
                    edit_min_d = cur_min;
                end else if (inc_act) begin
                    alarm_on_d = !alarm_on_q;
                end
            end
            ST_SET_HR: begin
                if (mode_act) state_d = ST_SET_MIN;
                else if (inc_act) edit_hr_d = 5'(wrap_inc({1'b0, edit_hr_q}, HR_LAST));
            end
            ST_SET_MIN: begin
                if (mode_act) state_d = ST_COMMIT;
                else if (inc_act) edit_min_d = wrap_inc(edit_min_q, MIN_LAST);
            end
            ST_COMMIT: begin
                state_d = ST_ALM_HR;
            end
            ST_ALM_HR: begin
                if (mode_act) state_d = ST_ALM_MIN;
                else if (inc_act) alarm_hr_d = 5'(wrap_inc({1'b0, alarm_hr_q}, HR_LAST));
            end
            ST_ALM_MIN: begin
                if (mode_act) state_d = ST_RUN;
                else if (inc_act) alarm_min_d = wrap_inc(alarm_min_q, MIN_LAST);
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Steady on outside editing; every newly entered edit state starts
        // lit and then flips once per second.
        if ((state_d != state_q) || (state_d == ST_RUN) || (state_d == ST_COMMIT)) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = !blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            edit_hr_q   <= '0;
            edit_min_q  <= '0;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            alarm_on_q  <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            edit_hr_q   <= edit_hr_d;
            edit_min_q  <= edit_min_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            alarm_on_q  <= alarm_on_d;
            blink_q     <= blink_d;
        end
    end

    clock_alarm_match #(
        .ALARM_TICKS (ALARM_TICKS)
    ) u_alarm_match (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .check_en   (live),
        .alarm_on   (alarm_on_q),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_hr   (alarm_hr_q),
        .alarm_min  (alarm_min_q),
        .dismiss    (dismiss),
        .alarm_fire (alarm_fire)
    );

    // cnt_en follows the tick combinationally; qualifying it with rst keeps
    // the time counter still while reset is held even if ticks keep coming.
    assign cnt_en    = tick_1hz && live && rst;
    assign ld        = (state_q == ST_COMMIT);
    assign ld_hr     = ld ? edit_hr_q : 5'd0;
    assign ld_min    = ld ? edit_min_q : 6'd0;
    assign ld_sec    = 6'd0;
    assign edit_hr   = edit_hr_q;
    assign edit_min  = edit_min_q;
    assign mode      = state_q;
    assign blink     = blink_q;
    assign alarm_hr  = alarm_hr_q;
    assign alarm_min = alarm_min_q;
    assign alarm_on  = alarm_on_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: a behavioural model predicts every
// cycle's outputs and every load strobe; a negedge monitor compares.
module tb_clock_set_ctrl;

    localparam int ALARM_TICKS = 60;
    localparam int S_RUN = 0, S_SH = 1, S_SM = 2, S_CM = 3, S_AH = 4, S_AM = 5;

    typedef struct packed {
        logic       cnt_en;
        logic       ld;
        logic [4:0] ld_hr;
        logic [5:0] ld_min;
        logic [5:0] ld_sec;
        logic [4:0] edit_hr;
        logic [5:0] edit_min;
        logic [2:0] mode;
        logic       blink;
        logic [4:0] alarm_hr;
        logic [5:0] alarm_min;
        logic       alarm_on;
        logic       alarm_fire;
    } snap_t;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } ldv_t;

    logic clk, rst, tick_1hz, btn_mode, btn_inc;
    logic [4:0] cur_hr;
    logic [5:0] cur_min, cur_sec;
    logic cnt_en, ld, blink, alarm_on, alarm_fire;
    logic [4:0] ld_hr, edit_hr, alarm_hr;
    logic [5:0] ld_min, ld_sec, edit_min, alarm_min;
    logic [2:0] mode;

    clock_set_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .cnt_en(cnt_en), .ld(ld), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .edit_hr(edit_hr), .edit_min(edit_min), .mode(mode), .blink(blink),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_on(alarm_on),
        .alarm_fire(alarm_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snap_t exp_q[$];
    ldv_t  ld_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Bench-side time counter (what the real time counter would hold).
    int cur_h = 10, cur_m = 20, cur_s = 33;

    // Reference model state, in plain clock-time terms.
    int m_st, m_eh, m_em, m_ah, m_am, m_fticks;
    bit m_on, m_fire, m_guard, m_blink;

    function automatic void model_reset();
        m_st = S_RUN; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
        m_on = 0; m_fire = 0; m_fticks = 0; m_guard = 0; m_blink = 1;
    endfunction

    task automatic step(input bit r, input bit t, input bit bm, input bit bi);
        snap_t e;
        int nst;
        bit live, trig, in_minute;
        @(posedge clk);
        #1;
        rst = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        cur_hr = 5'(cur_h); cur_min = 6'(cur_m); cur_sec = 6'(cur_s);
        if (!r) model_reset();
        live = r && (m_st == S_RUN || m_st == S_AH || m_st == S_AM);
        e = '0;
        e.cnt_en     = t && live;
        e.ld         = r && (m_st == S_CM);
        e.ld_hr      = e.ld ? 5'(m_eh) : 5'd0;
        e.ld_min     = e.ld ? 6'(m_em) : 6'd0;
        e.edit_hr    = 5'(m_eh);
        e.edit_min   = 6'(m_em);
        e.mode       = 3'(m_st);
        e.blink      = m_blink;
        e.alarm_hr   = 5'(m_ah);
        e.alarm_min  = 6'(m_am);
        e.alarm_on   = m_on;
        e.alarm_fire = m_fire;
        exp_q.push_back(e);
        if (e.ld) ld_q.push_back({e.ld_hr, e.ld_min, 6'd0});

        if (r) begin
            in_minute = (cur_h == m_ah) && (cur_m == m_am);
            trig = !m_fire && t && live && m_on && in_minute && cur_s == 0 && !m_guard;
            if (!in_minute) m_guard = 0;
            nst = m_st;
            if (m_fire && (bm || bi)) begin
                m_fire = 0;
            end else begin
                if (m_fire && t) begin
                    m_fticks++;
                    if (m_fticks == ALARM_TICKS) m_fire = 0;
                end
                case (m_st)
                    S_RUN: if (bm) begin nst = S_SH; m_eh = cur_h; m_em = cur_m; end
                           else if (bi) m_on = !m_on;
                    S_SH:  if (bm) nst = S_SM; else if (bi) m_eh = (m_eh + 1) % 24;
                    S_SM:  if (bm) nst = S_CM; else if (bi) m_em = (m_em + 1) % 60;
                    S_CM:  nst = S_AH;
                    S_AH:  if (bm) nst = S_AM; else if (bi) m_ah = (m_ah + 1) % 24;
                    S_AM:  if (bm) nst = S_RUN; else if (bi) m_am = (m_am + 1) % 60;
                    default: nst = S_RUN;
                endcase
            end
            if (trig) begin m_fire = 1; m_fticks = 0; m_guard = 1; end
            if (nst != m_st || nst == S_RUN || nst == S_CM) m_blink = 1;
            else if (t) m_blink = !m_blink;
            m_st = nst;
        end

        if (e.ld) begin
            cur_h = m_eh; cur_m = m_em; cur_s = 0;
        end else if (e.cnt_en) begin
            cur_s++;
            if (cur_s == 60) begin
                cur_s = 0; cur_m++;
                if (cur_m == 60) begin cur_m = 0; cur_h = (cur_h + 1) % 24; end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0);
    endtask

    task automatic incs(input int n, input bit with_ticks);
        for (int k = 0; k < n; k++) step(1, with_ticks && (k % 2 == 0), 0, 1);
    endtask

    // Monitor: one comparison per cycle against the scoreboard, plus a
    // value check on every load strobe the DUT presents.
    snap_t act, want;
    ldv_t  ldw;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cyc++;
            want = exp_q.pop_front();
            act = {cnt_en, ld, ld_hr, ld_min, ld_sec, edit_hr, edit_min, mode,
                   blink, alarm_hr, alarm_min, alarm_on, alarm_fire};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%h want=%h (mode %0d/%0d fire %b/%b blink %b/%b)",
                         cyc, act, want, act.mode, want.mode, act.alarm_fire,
                         want.alarm_fire, act.blink, want.blink);
            end
            if (ld === 1'b1) begin
                checks++;
                if (ld_q.size() == 0) begin
                    errors++;
                    $display("FAIL ld_unexpected cyc=%0d got ld=1 %0d:%0d:%0d want no load",
                             cyc, ld_hr, ld_min, ld_sec);
                end else begin
                    ldw = ld_q.pop_front();
                    if ({ld_hr, ld_min, ld_sec} !== ldw) begin
                        errors++;
                        $display("FAIL ld_value cyc=%0d got %0d:%0d:%0d want %0d:%0d:%0d",
                                 cyc, ld_hr, ld_min, ld_sec, ldw.hr, ldw.min, ldw.sec);
                    end
                end
            end
        end
    end

    initial begin
        rst = 0; tick_1hz = 0; btn_mode = 0; btn_inc = 0;
        cur_hr = '0; cur_min = '0; cur_sec = '0;
        model_reset();
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        idle(2);

        // Edit flow 10:20:33 -> 13:05:00, ticks arriving while editing.
        step(1, 0, 1, 0);
        incs(3, 1);
        step(1, 1, 1, 0);
        incs(45, 1);
        step(1, 0, 1, 0);
        step(1, 1, 0, 0);            // COMMIT cycle
        // Alarm 07:30, then arm it from RUN.
        incs(7, 1);
        step(1, 0, 1, 0);
        incs(30, 1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        idle(2);

        // Alarm fires, runs its full duration.
        cur_h = 7; cur_m = 30; cur_s = 0;
        step(1, 1, 0, 0);
        for (int k = 0; k < ALARM_TICKS + 2; k++) begin
            step(1, 0, 0, 0);
            step(1, 1, 0, 0);
        end
        // Fires again in a fresh minute; dismissed by inc; no re-fire.
        cur_h = 7; cur_m = 29; cur_s = 58;
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 1);
        idle(2);
        cur_h = 7; cur_m = 30; cur_s = 0;
        step(1, 1, 0, 0);
        idle(2);
        step(1, 1, 0, 0);
        // Fire then dismiss with mode: state must stay RUN.
        cur_h = 7; cur_m = 29; cur_s = 59;
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        idle(2);

        // Wraps and mode+inc collision.
        cur_h = 23; cur_m = 59; cur_s = 10;
        step(1, 0, 1, 0);
        incs(1, 0);
        step(1, 0, 1, 0);
        incs(3, 0);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        incs(17, 0);
        step(1, 0, 1, 0);
        incs(61, 0);
        step(1, 0, 1, 0);
        idle(2);

        // Reset mid-edit, no load afterwards.
        step(1, 0, 1, 0); step(1, 0, 1, 0); incs(2, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 0, 0); idle(3);

        // Random phase driven by the bench's time counter.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                cur_h = m_ah; cur_m = m_am; cur_s = 57;
            end
            if ($urandom_range(0, 899) == 0) step(0, 0, 0, 0);
            else step(1, $urandom_range(0, 2) == 0, $urandom_range(0, 13) == 0,
                      $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || ld_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d snapshots %0d loads pending want 0 0",
                     exp_q.size(), ld_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- HR_MAX, 23, last hour value before wrap.
- MIN_MAX, 59, last minute value before wrap.
- ALARM_TICKS, 60, alarm duration in tick_1hz pulses.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse, once per second.
- btn_mode  in  1  debounced one-cycle pulse; advances edit mode.
- btn_inc  in  1  debounced one-cycle pulse; increments field, toggles or dismisses the alarm.
- cur_hr / cur_min / cur_sec  in  5/6/6  live time from the time counter.
- cnt_en  out  1  advance enable to the time counter.
- ld  out  1  one-cycle load strobe to the time counter.
- ld_hr / ld_min / ld_sec  out  5/6/6  load values, valid while ld=1.
- edit_hr / edit_min  out  5/6  field values shown while editing.
- mode  out  3  current state encoding, for the display.
- blink  out  1  display blink for the edited field.
- alarm_hr / alarm_min  out  5/6  stored alarm time.
- alarm_on  out  1  alarm armed.
- alarm_fire  out  1  alarm sounding.

Function
REQ-003 The FSM SHALL have states RUN, SET_HR, SET_MIN, COMMIT, ALM_HR and ALM_MIN.
REQ-004 On btn_mode the FSM SHALL follow this sequence: RUN->SET_HR->SET_MIN->COMMIT->ALM_HR->ALM_MIN->RUN.
REQ-005 COMMIT SHALL last exactly one cycle and advance to ALM_HR unconditionally.
REQ-006 On RUN->SET_HR, edit_hr and edit_min SHALL capture cur_hr and cur_min in the same edge.
REQ-007 btn_inc SHALL increment edit_hr in SET_HR, wrapping HR_MAX->0.
REQ-008 btn_inc SHALL increment edit_min in SET_MIN, wrapping MIN_MAX->0.
REQ-009 btn_inc SHALL increment alarm_hr in ALM_HR and alarm_min in ALM_MIN, using the same wrap rules.
REQ-010 In COMMIT: ld=1, ld_hr=edit_hr, ld_min=edit_min, ld_sec=0; ld SHALL be 0 in every other state.
REQ-011 cnt_en SHALL equal tick_1hz in RUN, ALM_HR and ALM_MIN, and SHALL be 0 in SET_HR, SET_MIN and COMMIT (time frozen while editing).
REQ-012 If btn_mode and btn_inc arrive in the same cycle, btn_mode SHALL win and btn_inc SHALL be ignored.
REQ-013 In RUN with alarm_fire=0, btn_inc SHALL toggle alarm_on.
REQ-014 alarm_fire SHALL assert on the cycle after a tick_1hz in RUN or ALM_* when all of these hold: alarm_on=1, cur_hr=alarm_hr, cur_min=alarm_min, cur_sec=0.
REQ-015 alarm_fire SHALL clear after ALARM_TICKS ticks, or on btn_inc, or on btn_mode; the dismissing press SHALL have no other effect.
REQ-016 alarm_fire SHALL NOT re-trigger within the same matching minute.
REQ-017 blink SHALL be 1 in RUN and COMMIT, and SHALL toggle on each tick_1hz in SET_* and ALM_* states.
REQ-018 On entry to any SET_* or ALM_* state, blink SHALL start at 1.
REQ-019 Edit and alarm fields SHALL never hold out-of-range values; increments SHALL use exact-width compare, not modulo arithmetic.

Reset
REQ-020 rst=0 SHALL asynchronously force: state RUN, cnt_en=0, ld=0, ld_* =0, edit_* =0, alarm_hr=0, alarm_min=0, alarm_on=0, alarm_fire=0, blink=1, and the fire counter to 0.
REQ-021 A reset asserted mid-edit SHALL discard edit values and SHALL NOT issue ld.
REQ-022 Release SHALL take effect on the first clk edge after rst returns to 1.

Structure
REQ-023 A shared package SHALL hold the state enum, HR_MAX/MIN_MAX defaults, field widths and ALARM_TICKS.
REQ-024 One sub-module, clock_alarm_match, SHALL hold the match compare, the fire/duration counter and the re-trigger guard.

Verification
REQ-025 Edit flow: reset; cur=10:20:33; mode, inc x3, mode, inc x45, mode -> ld pulses once with 13:05:00 while cnt_en=0 throughout editing.
REQ-026 Wrap: edit_hr=23 + inc -> 0; edit_min=59 + inc -> 0; alarm_hr=23 + inc -> 0.
REQ-027 Alarm: alarm 07:30, alarm_on=1; cur 07:30:00 with tick -> alarm_fire=1 next cycle; 60 ticks later -> 0; no re-fire while cur_min=30.
REQ-028 Dismiss: during alarm_fire, inc -> alarm_fire=0 and alarm_on stays 1; simultaneous mode+inc in SET_MIN -> state COMMIT and edit_min unchanged.
REQ-029 Reset mid-edit: rst=0 while in SET_MIN -> immediate RUN with all outputs at reset values, no ld.
